// File: rtl/tx_frame_sched_if.sv
// UART transmit handshake between the frame scheduler (master) and the UART Tx (slave).
interface tx_frame_sched_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;

   modport master (output tx_start, output tx_data, input tx_busy);
   modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/tx_frame_sched.sv
// Telemetry frame scheduler: serialises periodic/alarm timestamp+temperature frames to a UART Tx.
// Optional feature macro: TXS_CHKSUM_EN appends an XOR checksum byte (8-byte frames).
module tx_frame_sched #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned GAP_CYC   = 16,
   parameter int unsigned TMO_CYC   = 1000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick15,
   input  logic                     alarm,
   input  logic [5:0]               hsec,
   input  logic [5:0]               hmin,
   input  logic [4:0]               hhour,
   input  logic [4:0]               hday,
   input  logic [3:0]               hmon,
   input  logic [7:0]               temp,
   tx_frame_sched_if.master         tx,
   output logic                     frame_act,
   output logic                     frame_kind,
   output logic                     drop,
   output logic                     tmo_err
);

`ifdef TXS_CHKSUM_EN
   localparam int unsigned NBYTES = 8;
`else
   localparam int unsigned NBYTES = 7;
`endif
   localparam logic [2:0]  LAST_IDX = 3'(NBYTES - 1);
   localparam int unsigned TW       = $clog2(TMO_CYC + 1);
   localparam int unsigned GW       = $clog2(GAP_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_ACC  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5
   } state_t;

   state_t        state_r;
   logic [2:0]    idx_r;
   logic [TW-1:0] tmo_cnt_r;
   logic [GW-1:0] gap_cnt_r;
   logic          pend_p_r, pend_a_r, alarm_q_r;
   logic          tx_start_r, frame_act_r, frame_kind_r, drop_r, tmo_err_r;
   logic [7:0]    tx_data_r;
   logic [3:0]    mon_r;
   logic [4:0]    day_r, hour_r;
   logic [5:0]    min_r, sec_r;
   logic [7:0]    temp_r;

   logic          alarm_edge_s, grant_a_s, grant_p_s, tmo_hit_s;
   logic [2:0]    load_idx_s;
   logic [7:0]    byte_sel_s;

`ifdef TXS_CHKSUM_EN
   function automatic logic [7:0] chk_xor(input logic [7:0] b1, input logic [7:0] b2,
                                          input logic [7:0] b3, input logic [7:0] b4,
                                          input logic [7:0] b5, input logic [7:0] b6);
      return b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6;
   endfunction
`endif

   assign alarm_edge_s = alarm & ~alarm_q_r;
   assign grant_a_s    = (state_r == ST_IDLE) & pend_a_r;
   assign grant_p_s    = (state_r == ST_IDLE) & ~pend_a_r & pend_p_r;
   assign tmo_hit_s    = (tmo_cnt_r == TMO_LAST);

   // Byte about to be launched: index 0 from LOAD, next index from GAP.
   always_comb begin
      load_idx_s = 3'd0;
      if (state_r == ST_GAP) begin
         load_idx_s = idx_r + 3'd1;
      end else begin
         load_idx_s = 3'd0;
      end
      byte_sel_s = 8'h00;
      case (load_idx_s)
         3'd0:    byte_sel_s = SYNC_BYTE;
         3'd1:    byte_sel_s = {frame_kind_r, 3'b000, mon_r};
         3'd2:    byte_sel_s = {3'b000, day_r};
         3'd3:    byte_sel_s = {3'b000, hour_r};
         3'd4:    byte_sel_s = {2'b00, min_r};
         3'd5:    byte_sel_s = {2'b00, sec_r};
         3'd6:    byte_sel_s = temp_r;
`ifdef TXS_CHKSUM_EN
         3'd7:    byte_sel_s = chk_xor({frame_kind_r, 3'b000, mon_r}, {3'b000, day_r},
                                       {3'b000, hour_r}, {2'b00, min_r}, {2'b00, sec_r}, temp_r);
`endif
         default: byte_sel_s = 8'h00;
      endcase
   end

   // Request capture: single-entry pending flags, alarm edge detect, lost-tick pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alarm_q_r <= 1'b0;
         pend_a_r  <= 1'b0;
         pend_p_r  <= 1'b0;
         drop_r    <= 1'b0;
      end else begin
         alarm_q_r <= alarm;
         pend_a_r  <= (pend_a_r & ~grant_a_s) | alarm_edge_s;
         pend_p_r  <= (pend_p_r & ~grant_p_s) | tick15;
         drop_r    <= tick15 & pend_p_r & ~grant_p_s;
      end
   end

   // Frame sequencer with registered UART/status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         idx_r        <= 3'd0;
         tmo_cnt_r    <= '0;
         gap_cnt_r    <= '0;
         tx_start_r   <= 1'b0;
         tx_data_r    <= 8'h00;
         frame_act_r  <= 1'b0;
         frame_kind_r <= 1'b0;
         tmo_err_r    <= 1'b0;
         mon_r        <= 4'd0;
         day_r        <= 5'd0;
         hour_r       <= 5'd0;
         min_r        <= 6'd0;
         sec_r        <= 6'd0;
         temp_r       <= 8'h00;
      end else begin
         tx_start_r <= 1'b0;
         tmo_err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_a_s || grant_p_s) begin
                  state_r      <= ST_LOAD;
                  frame_kind_r <= grant_a_s;
                  mon_r        <= hmon;
                  day_r        <= hday;
                  hour_r       <= hhour;
                  min_r        <= hmin;
                  sec_r        <= hsec;
                  temp_r       <= temp;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               state_r     <= ST_START;
               idx_r       <= 3'd0;
               frame_act_r <= 1'b1;
               tx_start_r  <= 1'b1;
               tx_data_r   <= byte_sel_s;
            end
            ST_START: begin
               state_r   <= ST_WAIT_ACC;
               tmo_cnt_r <= '0;
            end
            ST_WAIT_ACC: begin
               if (tx.tx_busy) begin
                  state_r   <= ST_WAIT_DONE;
                  tmo_cnt_r <= '0;
               end else if (tmo_hit_s) begin
                  state_r     <= ST_IDLE;
                  idx_r       <= 3'd0;
                  frame_act_r <= 1'b0;
                  tmo_err_r   <= 1'b1;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!tx.tx_busy) begin
                  state_r   <= ST_GAP;
                  gap_cnt_r <= '0;
               end else if (tmo_hit_s) begin
                  state_r     <= ST_IDLE;
                  idx_r       <= 3'd0;
                  frame_act_r <= 1'b0;
                  tmo_err_r   <= 1'b1;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt_r != GAP_LAST) begin
                  gap_cnt_r <= gap_cnt_r + GW'(1);
               end else if (idx_r == LAST_IDX) begin
                  state_r     <= ST_IDLE;
                  idx_r       <= 3'd0;
                  frame_act_r <= 1'b0;
               end else begin
                  state_r    <= ST_START;
                  idx_r      <= load_idx_s;
                  tx_start_r <= 1'b1;
                  tx_data_r  <= byte_sel_s;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               idx_r       <= 3'd0;
               frame_act_r <= 1'b0;
            end
         endcase
      end
   end

   assign tx.tx_start = tx_start_r;
   assign tx.tx_data  = tx_data_r;
   assign frame_act   = frame_act_r;
   assign frame_kind  = frame_kind_r;
   assign drop        = drop_r;
   assign tmo_err     = tmo_err_r;

endmodule
